// File: rtl/mdu_pkg.sv
// Shared types, constants and arithmetic helpers for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDivSetup,
        StDivIter,
        StDivFix,
        StDone
    } mdu_state_t;

    localparam int unsigned MUL_LAT_DEFAULT = 2;
    localparam int unsigned DIV_ITERS       = 32;

    // Low 64 bits of the product of the extended operands equal the signed or unsigned product.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = {{32{sgn & a[31]}}, a};
        bx = {{32{sgn & b[31]}}, b};
        return ax * bx;
    endfunction

    // One restoring-division step: returns {remainder, quotient} after shifting in quo[31].
    function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                             input logic [31:0] dvs);
        logic [32:0] shifted;
        logic [33:0] diff;
        shifted = {rem, quo[31]};
        diff    = {1'b0, shifted} - {2'b00, dvs};
        if (diff[33]) begin
            return {shifted[31:0], quo[30:0], 1'b0};
        end
        return {diff[31:0], quo[30:0], 1'b1};
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Execute-stage <-> MDU request/status bundle.
interface mdu_ctrl_if;
    logic                  req_valid;
    mdu_pkg::mdu_op_t      req_op;
    logic [31:0]           src_a;
    logic [31:0]           src_b;
    logic                  flush;
    logic                  mul_div_stall;
    logic                  busy;
    logic [31:0]           hi_data;
    logic [31:0]           lo_data;

    modport master (
        output req_valid, req_op, src_a, src_b, flush,
        input  mul_div_stall, busy, hi_data, lo_data
    );

    modport slave (
        input  req_valid, req_op, src_a, src_b, flush,
        output mul_div_stall, busy, hi_data, lo_data
    );
endinterface

// File: rtl/mdu_divider.sv
// Iterative restoring divider datapath: captures operands on start, takes magnitudes and the
// first quotient bit in the setup cycle, then one quotient bit per step. Sign fix-up is applied
// combinationally on the outputs so the controller can commit them in its fix cycle.
module mdu_divider
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        setup_i,
    input  logic        step_i,
    input  logic        abort_i,
    output logic        last_o,
    output logic        done_o,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic [31:0] a_raw_q, b_raw_q;
    logic        sgn_q;
    logic [31:0] rem_q, quo_q, dvs_q;
    logic        q_neg_q, r_neg_q;
    logic [5:0]  cnt_q;
    logic        done_q;

    logic [31:0] a_abs, b_abs;
    logic [63:0] first_step, next_step;

    // Magnitudes only for signed divides; the setup cycle also performs the first iteration.
    always_comb begin
        a_abs      = (sgn_q && a_raw_q[31]) ? -a_raw_q : a_raw_q;
        b_abs      = (sgn_q && b_raw_q[31]) ? -b_raw_q : b_raw_q;
        first_step = div_step(32'd0, a_abs, b_abs);
        next_step  = div_step(rem_q, quo_q, dvs_q);
    end

    assign last_o = step_i && (cnt_q == 6'(DIV_ITERS - 1));
    assign done_o = done_q;
    assign quo_o  = q_neg_q ? -quo_q : quo_q;
    assign rem_o  = r_neg_q ? -rem_q : rem_q;

    // Operand capture, setup and per-cycle iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_raw_q <= '0;
            b_raw_q <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (abort_i) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start_i) begin
            a_raw_q <= a_i;
            b_raw_q <= b_i;
            sgn_q   <= signed_i;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (setup_i) begin
            dvs_q          <= b_abs;
            q_neg_q        <= sgn_q & (a_raw_q[31] ^ b_raw_q[31]);
            r_neg_q        <= sgn_q & a_raw_q[31];
            {rem_q, quo_q} <= first_step;
            cnt_q          <= 6'd1;
        end else if (step_i) begin
            {rem_q, quo_q} <= next_step;
            cnt_q          <= cnt_q + 6'd1;
            if (last_o) begin
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencing controller: owns HI/LO, runs the multiply pipeline and the iterative divider,
// and stalls the front of the pipeline until the result is committed.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  mdu_io
);

    mdu_state_t  state_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] mul_a_q, mul_b_q;
    logic        mul_sgn_q;
    logic [2:0]  cnt_q;

    logic        req_mul, req_div, accept, stall;
    logic [63:0] prod_req, prod_held;
    logic        div_last, div_done;
    logic [31:0] div_quo, div_rem;

    // Request decode; the held-operand product is a multicycle path closed by MUL_LAT.
    always_comb begin
        req_mul   = (mdu_io.req_op == MDU_MULT) || (mdu_io.req_op == MDU_MULTU);
        req_div   = (mdu_io.req_op == MDU_DIV) || (mdu_io.req_op == MDU_DIVU);
        accept    = (state_q == StIdle) && mdu_io.req_valid && !mdu_io.flush;
        prod_req  = mul64(mdu_io.src_a, mdu_io.src_b, mdu_io.req_op == MDU_MULT);
        prod_held = mul64(mul_a_q, mul_b_q, mul_sgn_q);
    end

    mdu_divider u_divider (
        .clk      (clk),
        .reset    (reset),
        .start_i  (accept && req_div),
        .signed_i (mdu_io.req_op == MDU_DIV),
        .a_i      (mdu_io.src_a),
        .b_i      (mdu_io.src_b),
        .setup_i  ((state_q == StDivSetup) && !mdu_io.flush),
        .step_i   ((state_q == StDivIter) && !mdu_io.flush),
        .abort_i  (mdu_io.flush),
        .last_o   (div_last),
        .done_o   (div_done),
        .quo_o    (div_quo),
        .rem_o    (div_rem)
    );

    // Controller FSM and architectural HI/LO; flush drops any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_sgn_q <= 1'b0;
        end else if (mdu_io.flush) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mdu_io.req_valid) begin
                        case (mdu_io.req_op)
                            MDU_MULT, MDU_MULTU: begin
                                mul_a_q   <= mdu_io.src_a;
                                mul_b_q   <= mdu_io.src_b;
                                mul_sgn_q <= (mdu_io.req_op == MDU_MULT);
                                if (MUL_LAT == 1) begin
                                    {hi_q, lo_q} <= prod_req;
                                    state_q      <= StDone;
                                end else begin
                                    cnt_q   <= 3'd1;
                                    state_q <= StMul;
                                end
                            end
                            MDU_DIV, MDU_DIVU: state_q <= StDivSetup;
                            MDU_MTHI:          hi_q    <= mdu_io.src_a;
                            MDU_MTLO:          lo_q    <= mdu_io.src_a;
                            default:           ;
                        endcase
                    end
                end
                StMul: begin
                    if (cnt_q == 3'(MUL_LAT - 1)) begin
                        {hi_q, lo_q} <= prod_held;
                        cnt_q        <= '0;
                        state_q      <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StDivSetup: state_q <= StDivIter;
                StDivIter: begin
                    if (div_last) begin
                        state_q <= StDivFix;
                    end
                end
                StDivFix: begin
                    if (div_done) begin
                        hi_q <= div_rem;
                        lo_q <= div_quo;
                    end
                    state_q <= StDone;
                end
                // Request still held here is the retiring instruction, so it is not re-issued.
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stall is combinational so the accept cycle itself already holds the front end.
    always_comb begin
        stall = 1'b0;
        if (!mdu_io.flush) begin
            unique case (state_q)
                StIdle:                                 stall = mdu_io.req_valid &&
                                                                (req_mul || req_div);
                StMul, StDivSetup, StDivIter, StDivFix: stall = 1'b1;
                default:                                stall = 1'b0;
            endcase
        end
    end

    assign mdu_io.mul_div_stall = stall;
    assign mdu_io.busy          = (state_q != StIdle);
    assign mdu_io.hi_data       = hi_q;
    assign mdu_io.lo_data       = lo_q;

endmodule
